// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- multicycle MIPS control FSM.
//
// This block steps the datapath through FETCH, DECODE, EXEC, MEM and WB.
// It decodes opcode/func in DECODE and latches the instruction class at the
// end of that cycle. Every later state drives its controls from the state
// and the latched class only.
//
// The control outputs are combinational from the state and the class
// (Moore). The one exception is DECODE, which decodes the live IR fields.
// While reset is high, every strobe and select is forced to 0, so an
// instruction that is aborted by reset does not write anything.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   opcode, func        instr[31:26] and instr[5:0] from the IR
//   zero                ALU equality flag (the NPC consumes it, not this FSM)
//   PCWr, IRWr          PC / IR load enables
//   beq, jal, jr        NPC source selects
//   ALUOP, EXTOP, BSel  ALU operation, immediate extension, operand-B select
//   WRSel, WDSel        GRF write-address and write-data selects
//   RFWr, DMWr          GRF and DM write enables
//   state               current FSM state (debug)
//   illegal             one-cycle pulse in DECODE on an unrecognised encoding
//
// Optional feature, macro MULTICYCLE_CTRL_PERF_EN: adds cycle_cnt, which
// counts non-reset cycles, and instr_cnt, which counts retired instructions.
// Both are CNT_W bits wide and wrap.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  output logic       PCWr,
  output logic       IRWr,
  output logic       beq,
  output logic       jal,
  output logic       jr,
  output logic [2:0] ALUOP,
  output logic       EXTOP,
  output logic [1:0] WRSel,
  output logic       BSel,
  output logic [1:0] WDSel,
  output logic       RFWr,
  output logic       DMWr,
  output logic [2:0] state,
  output logic       illegal
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    CL_NOP, CL_ADDU, CL_SUBU, CL_JR, CL_ORI, CL_LW,
    CL_SW, CL_BEQ, CL_LUI, CL_JAL, CL_ILL
  } class_t;

  state_t state_q;
  class_t cls_q;
  class_t dec_cls;

  // The NPC consumes the branch flag directly, so no state transition depends on it.
  logic unused_zero;
  assign unused_zero = zero;

  assign state = state_q;

  // Instruction decode of the live IR fields. This is only meaningful in DECODE.
  always_comb begin
    // NOTE: a default assignment ahead of the case keeps the logic combinational;
    // a path that leaves dec_cls unassigned would infer a latch.
    dec_cls = CL_ILL;
    case (opcode)
      6'b000000:
        case (func)
          6'b100001: dec_cls = CL_ADDU;
          6'b100011: dec_cls = CL_SUBU;
          6'b001000: dec_cls = CL_JR;
          6'b000000: dec_cls = CL_NOP;
          default:   dec_cls = CL_ILL;
        endcase
      6'b001101: dec_cls = CL_ORI;
      6'b100011: dec_cls = CL_LW;
      6'b101011: dec_cls = CL_SW;
      6'b000100: dec_cls = CL_BEQ;
      6'b001111: dec_cls = CL_LUI;
      6'b000011: dec_cls = CL_JAL;
      default:   dec_cls = CL_ILL;
    endcase
  end

  // State and class registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so that every
    // register samples its pre-edge values.
    if (reset) begin
      state_q <= FETCH;
      cls_q   <= CL_NOP;
    end else begin
      case (state_q)
        FETCH:  state_q <= DECODE;
        DECODE: begin
          cls_q <= dec_cls;
          case (dec_cls)
            CL_JR, CL_JAL, CL_NOP, CL_ILL: state_q <= FETCH;
            default:                       state_q <= EXEC;
          endcase
        end
        EXEC:
          case (cls_q)
            CL_LW, CL_SW: state_q <= MEM;
            CL_BEQ:       state_q <= FETCH;
            default:      state_q <= WB;
          endcase
        MEM:     state_q <= (cls_q == CL_LW) ? WB : FETCH;
        default: state_q <= FETCH;   // WB, plus the unreachable encodings 5-7
      endcase
    end
  end

  // Moore outputs. The ALU controls stay constant for the class from EXEC through WB.
  always_comb begin
    PCWr = 1'b0; IRWr = 1'b0; beq = 1'b0; jal = 1'b0; jr = 1'b0;
    ALUOP = 3'b000; EXTOP = 1'b0; WRSel = 2'b00; BSel = 1'b0; WDSel = 2'b00;
    RFWr = 1'b0; DMWr = 1'b0; illegal = 1'b0;

    if (state_q == EXEC || state_q == MEM || state_q == WB) begin
      case (cls_q)
        CL_SUBU: ALUOP = 3'b001;
        CL_ORI:  begin ALUOP = 3'b010; BSel = 1'b1; end
        CL_LUI:  begin ALUOP = 3'b011; BSel = 1'b1; end
        CL_LW,
        CL_SW:   begin BSel = 1'b1; EXTOP = 1'b1; end
        CL_BEQ:  begin ALUOP = 3'b001; EXTOP = 1'b1; end
        default: ;
      endcase
    end

    case (state_q)
      FETCH:  IRWr = 1'b1;
      DECODE:
        case (dec_cls)
          CL_JR:  begin jr = 1'b1; PCWr = 1'b1; end
          CL_JAL: begin
            jal = 1'b1; PCWr = 1'b1; RFWr = 1'b1;
            WRSel = 2'b10; WDSel = 2'b10;
          end
          CL_NOP: PCWr = 1'b1;
          CL_ILL: begin PCWr = 1'b1; illegal = 1'b1; end
          default: ;
        endcase
      EXEC:
        if (cls_q == CL_BEQ) begin
          beq  = 1'b1;
          PCWr = 1'b1;
        end
      MEM:
        if (cls_q == CL_SW) begin
          DMWr = 1'b1;
          PCWr = 1'b1;
        end
      WB: begin
        RFWr = 1'b1;
        PCWr = 1'b1;
        case (cls_q)
          CL_ADDU, CL_SUBU: WRSel = 2'b01;
          CL_LW:            WDSel = 2'b01;
          default: ;
        endcase
      end
      default: ;
    endcase

    // Reset aborts the instruction in flight. No write takes place on the reset edge.
    if (reset) begin
      PCWr = 1'b0; IRWr = 1'b0; beq = 1'b0; jal = 1'b0; jr = 1'b0;
      ALUOP = 3'b000; EXTOP = 1'b0; WRSel = 2'b00; BSel = 1'b0; WDSel = 2'b00;
      RFWr = 1'b0; DMWr = 1'b0; illegal = 1'b0;
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (PCWr) instr_cnt <= instr_cnt + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl. Each vector is one clock cycle: the inputs
// for that cycle and the control word expected in the same cycle. The inputs
// are driven 1 time unit after the rising edge. The expected word goes into
// a scoreboard queue and is popped and compared on the falling edge.
module tb_multicycle_ctrl;

  localparam int CNT_W = 32;

  typedef struct packed {
    logic [2:0] st;
    logic       pcwr, irwr, rfwr, dmwr, beq, jal, jr, ill;
    logic [2:0] aluop;
    logic       extop, bsel;
    logic [1:0] wrsel, wdsel;
  } ctrl_t;

  typedef struct packed {
    logic       rst;
    logic [5:0] op, fn;
    logic       z;
    ctrl_t      exp;
  } vec_t;

  localparam logic [5:0] OP_R = 6'b000000, OP_ORI = 6'b001101, OP_LW = 6'b100011,
                         OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_LUI = 6'b001111,
                         OP_JAL = 6'b000011, OP_BAD = 6'b111111;
  localparam logic [5:0] FN_ADDU = 6'b100001, FN_SUBU = 6'b100011, FN_JR = 6'b001000;

  logic clk = 1'b0, reset = 1'b1, zero = 1'b0;
  logic [5:0] opcode = '0, func = '0;
  logic PCWr, IRWr, beq, jal, jr, EXTOP, BSel, RFWr, DMWr, illegal;
  logic [2:0] ALUOP, state;
  logic [1:0] WRSel, WDSel;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;
`endif

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func(func), .zero(zero),
    .PCWr(PCWr), .IRWr(IRWr), .beq(beq), .jal(jal), .jr(jr), .ALUOP(ALUOP),
    .EXTOP(EXTOP), .WRSel(WRSel), .BSel(BSel), .WDSel(WDSel), .RFWr(RFWr),
    .DMWr(DMWr), .state(state), .illegal(illegal)
`ifdef MULTICYCLE_CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  vec_t  vecs[$];
  ctrl_t exp_q[$];
  int n_vec = 0, n_fail = 0;

  // Argument order: state, pcwr, irwr, rfwr, dmwr, beq, jal, jr, illegal, aluop, extop, bsel, wrsel, wdsel
  function automatic ctrl_t mk(input logic [2:0] st, input logic pc, ir, rf, dm, bq, jl, j, il,
                               input logic [2:0] alu, input logic ext, bs,
                               input logic [1:0] wrs, wds);
    ctrl_t c;
    c = '{st, pc, ir, rf, dm, bq, jl, j, il, alu, ext, bs, wrs, wds};
    return c;
  endfunction

  task automatic v(input logic rst, input logic [5:0] op, fn, input logic z, input ctrl_t e);
    vec_t t;
    t = '{rst, op, fn, z, e};
    vecs.push_back(t);
  endtask

  // FETCH, then a DECODE cycle with no strobes (every class that continues to EXEC).
  task automatic fd(input logic [5:0] op, fn);
    v(0, op, fn, 0, mk(0, 0,1,0,0, 0,0,0,0, 3'b000,0,0, 2'b00,2'b00));
    v(0, op, fn, 0, mk(1, 0,0,0,0, 0,0,0,0, 3'b000,0,0, 2'b00,2'b00));
  endtask

  task automatic f(input logic [5:0] op, fn);
    v(0, op, fn, 0, mk(0, 0,1,0,0, 0,0,0,0, 3'b000,0,0, 2'b00,2'b00));
  endtask

  task automatic check(input string name, input ctrl_t got, input ctrl_t exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got st=%0d pc=%b ir=%b rf=%b dm=%b bq=%b jal=%b jr=%b ill=%b alu=%b ext=%b bs=%b wrs=%b wds=%b, expected %h (got %h)",
               name, got.st, got.pcwr, got.irwr, got.rfwr, got.dmwr, got.beq, got.jal, got.jr,
               got.ill, got.aluop, got.extop, got.bsel, got.wrsel, got.wdsel, exp, got);
    end
  endtask

`ifdef MULTICYCLE_CTRL_PERF_EN
  task automatic check_cnt(input string name, input logic [CNT_W-1:0] got, exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask
`endif

  initial begin
    ctrl_t got, e;
    logic prev_rst, prev_pcwr;
    logic [CNT_W-1:0] m_cyc, m_ins;
    prev_rst = 1'b1; prev_pcwr = 1'b0; m_cyc = '0; m_ins = '0;

    // Reset is held for two cycles, and every output is 0 throughout.
    v(1, 0, 0, 0, mk(0, 0,0,0,0, 0,0,0,0, 3'b000,0,0, 2'b00,2'b00));
    v(1, 0, 0, 0, mk(0, 0,0,0,0, 0,0,0,0, 3'b000,0,0, 2'b00,2'b00));
    // ori: 0,1,2,4. The func field carries immediate bits and has no effect.
    fd(OP_ORI, 6'h2a);
    v(0, OP_ORI, 6'h2a, 0, mk(2, 0,0,0,0, 0,0,0,0, 3'b010,0,1, 2'b00,2'b00));
    v(0, OP_ORI, 6'h2a, 0, mk(4, 1,0,1,0, 0,0,0,0, 3'b010,0,1, 2'b00,2'b00));
    // addu
    fd(OP_R, FN_ADDU);
    v(0, OP_R, FN_ADDU, 0, mk(2, 0,0,0,0, 0,0,0,0, 3'b000,0,0, 2'b00,2'b00));
    v(0, OP_R, FN_ADDU, 0, mk(4, 1,0,1,0, 0,0,0,0, 3'b000,0,0, 2'b01,2'b00));
    // subu
    fd(OP_R, FN_SUBU);
    v(0, OP_R, FN_SUBU, 0, mk(2, 0,0,0,0, 0,0,0,0, 3'b001,0,0, 2'b00,2'b00));
    v(0, OP_R, FN_SUBU, 0, mk(4, 1,0,1,0, 0,0,0,0, 3'b001,0,0, 2'b01,2'b00));
    // lui
    fd(OP_LUI, 6'h15);
    v(0, OP_LUI, 6'h15, 0, mk(2, 0,0,0,0, 0,0,0,0, 3'b011,0,1, 2'b00,2'b00));
    v(0, OP_LUI, 6'h15, 0, mk(4, 1,0,1,0, 0,0,0,0, 3'b011,0,1, 2'b00,2'b00));
    // lw: 5 cycles, with WDSel=01 in WB
    fd(OP_LW, 6'h04);
    v(0, OP_LW, 6'h04, 0, mk(2, 0,0,0,0, 0,0,0,0, 3'b000,1,1, 2'b00,2'b00));
    v(0, OP_LW, 6'h04, 0, mk(3, 0,0,0,0, 0,0,0,0, 3'b000,1,1, 2'b00,2'b00));
    v(0, OP_LW, 6'h04, 0, mk(4, 1,0,1,0, 0,0,0,0, 3'b000,1,1, 2'b00,2'b01));
    // sw: 4 cycles, with DMWr only in MEM
    fd(OP_SW, 6'h08);
    v(0, OP_SW, 6'h08, 0, mk(2, 0,0,0,0, 0,0,0,0, 3'b000,1,1, 2'b00,2'b00));
    v(0, OP_SW, 6'h08, 0, mk(3, 1,0,0,1, 0,0,0,0, 3'b000,1,1, 2'b00,2'b00));
    // beq, taken and then not taken: 3 cycles each, and zero has no effect on the controls
    fd(OP_BEQ, 6'h01);
    v(0, OP_BEQ, 6'h01, 1, mk(2, 1,0,0,0, 1,0,0,0, 3'b001,1,0, 2'b00,2'b00));
    fd(OP_BEQ, 6'h01);
    v(0, OP_BEQ, 6'h01, 0, mk(2, 1,0,0,0, 1,0,0,0, 3'b001,1,0, 2'b00,2'b00));
    // jal, then jr: 2 cycles each
    f(OP_JAL, 6'h10);
    v(0, OP_JAL, 6'h10, 0, mk(1, 1,0,1,0, 0,1,0,0, 3'b000,0,0, 2'b10,2'b10));
    f(OP_R, FN_JR);
    v(0, OP_R, FN_JR, 0, mk(1, 1,0,0,0, 0,0,1,0, 3'b000,0,0, 2'b00,2'b00));
    // nop
    f(OP_R, 6'b000000);
    v(0, OP_R, 6'b000000, 0, mk(1, 1,0,0,0, 0,0,0,0, 3'b000,0,0, 2'b00,2'b00));
    // illegal opcode, then an unknown R-type func
    f(OP_BAD, 6'h00);
    v(0, OP_BAD, 6'h00, 0, mk(1, 1,0,0,0, 0,0,0,1, 3'b000,0,0, 2'b00,2'b00));
    f(OP_R, 6'b000001);
    v(0, OP_R, 6'b000001, 0, mk(1, 1,0,0,0, 0,0,0,1, 3'b000,0,0, 2'b00,2'b00));
    // addu aborted by reset in WB: no strobes on that edge, and it restarts in FETCH
    fd(OP_R, FN_ADDU);
    v(0, OP_R, FN_ADDU, 0, mk(2, 0,0,0,0, 0,0,0,0, 3'b000,0,0, 2'b00,2'b00));
    v(1, OP_R, FN_ADDU, 0, mk(4, 0,0,0,0, 0,0,0,0, 3'b000,0,0, 2'b00,2'b00));
    f(OP_R, 6'b000000);
    v(0, OP_R, 6'b000000, 0, mk(1, 1,0,0,0, 0,0,0,0, 3'b000,0,0, 2'b00,2'b00));
    f(OP_ORI, 6'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      reset  = vecs[i].rst;
      opcode = vecs[i].op;
      func   = vecs[i].fn;
      zero   = vecs[i].z;
      exp_q.push_back(vecs[i].exp);
      // Counter model: the edge that just passed acted on the previous cycle's inputs.
      if (prev_rst) begin
        m_cyc = '0;
        m_ins = '0;
      end else begin
        m_cyc = m_cyc + 1'b1;
        if (prev_pcwr) m_ins = m_ins + 1'b1;
      end
      prev_rst  = vecs[i].rst;
      prev_pcwr = vecs[i].exp.pcwr;
      @(negedge clk);
      got = '{state, PCWr, IRWr, RFWr, DMWr, beq, jal, jr, illegal, ALUOP, EXTOP, BSel, WRSel, WDSel};
      e = exp_q.pop_front();
      check($sformatf("vec%0d", i), got, e);
`ifdef MULTICYCLE_CTRL_PERF_EN
      check_cnt($sformatf("cycle_cnt%0d", i), cycle_cnt, m_cyc);
      check_cnt($sformatf("instr_cnt%0d", i), instr_cnt, m_ins);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
